wb_bus_arbiter_2m4s: RTL

- Wishbone interconnect directly downstream of the CPU's two Wishbone bus interfaces: m0 is the data port, m1 is the instruction port.
- Arbitrates the two masters onto one shared slave bus and decodes the address onto 4 slaves (SDRAM, flash, UART, GPIO).
- Guarantees every master cycle terminates, via decode-miss and timeout auto-ack, so a master stall request never hangs the pipeline.

---
 rtl/wb_bus_arbiter_2m4s_pkg.sv | 21 ++
 rtl/wb_bus_arbiter_2m4s_if.sv | 39 +++
 rtl/wb_bus_arbiter_2m4s_decoder.sv | 22 ++
 rtl/wb_bus_arbiter_2m4s.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/wb_bus_arbiter_2m4s_pkg.sv
// Shared types and constants for the two-master / four-slave Wishbone interconnect.
package wb_bus_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;
  localparam int N_SLV     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GNT0    = 2'b01,
    GNT1    = 2'b10,
    ERR_ACK = 2'b11
  } arb_state_e;

  localparam logic [1:0] SDRAM = 2'd0;
  localparam logic [1:0] FLASH = 2'd1;
  localparam logic [1:0] UART  = 2'd2;
  localparam logic [1:0] GPIO  = 2'd3;

endpackage

// File: rtl/wb_bus_arbiter_2m4s_if.sv
// Bundle of both master ports and the shared slave bus around the interconnect.
// The slave modport is the interconnect's view; the master modport is the CPU/slave side.
interface wb_bus_arbiter_2m4s_if;
  import wb_bus_pkg::*;

  logic [WB_ADDR_W-1:0]       m0_addr_i, m1_addr_i;
  logic [WB_DATA_W-1:0]       m0_data_i, m1_data_i;
  logic                       m0_we_i, m1_we_i;
  logic [WB_SEL_W-1:0]        m0_sel_i, m1_sel_i;
  logic                       m0_stb_i, m1_stb_i;
  logic                       m0_cyc_i, m1_cyc_i;
  logic [WB_DATA_W-1:0]       m0_data_o, m1_data_o;
  logic                       m0_ack_o, m1_ack_o;
  logic [WB_ADDR_W-1:0]       s_addr_o;
  logic [WB_DATA_W-1:0]       s_data_o;
  logic                       s_we_o;
  logic [WB_SEL_W-1:0]        s_sel_o;
  logic [N_SLV-1:0]           s_stb_o, s_cyc_o;
  logic [N_SLV*WB_DATA_W-1:0] s_data_i;
  logic [N_SLV-1:0]           s_ack_i;
  logic                       bus_err_o;

  modport slave (
    input  m0_addr_i, m1_addr_i, m0_data_i, m1_data_i, m0_we_i, m1_we_i,
           m0_sel_i, m1_sel_i, m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i,
           s_data_i, s_ack_i,
    output m0_data_o, m1_data_o, m0_ack_o, m1_ack_o,
           s_addr_o, s_data_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o, bus_err_o
  );

  modport master (
    output m0_addr_i, m1_addr_i, m0_data_i, m1_data_i, m0_we_i, m1_we_i,
           m0_sel_i, m1_sel_i, m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i,
           s_data_i, s_ack_i,
    input  m0_data_o, m1_data_o, m0_ack_o, m1_ack_o,
           s_addr_o, s_data_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o, bus_err_o
  );

endinterface

// File: rtl/wb_bus_arbiter_2m4s_decoder.sv
// Combinational slave decode: 4-bit address field to one-hot slave select plus miss flag.
module wb_addr_decoder
  import wb_bus_pkg::*;
(
  input  logic [3:0]       field_i,
  output logic [N_SLV-1:0] hot_o,
  output logic             miss_o
);

  always_comb begin
    hot_o  = '0;
    miss_o = 1'b0;
    case (field_i)
      4'(SDRAM): hot_o[SDRAM] = 1'b1;
      4'(FLASH): hot_o[FLASH] = 1'b1;
      4'(UART):  hot_o[UART]  = 1'b1;
      4'(GPIO):  hot_o[GPIO]  = 1'b1;
      default:   miss_o       = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_bus_arbiter_2m4s.sv
// Two-master Wishbone arbiter with 4-slave decode and decode-miss/timeout auto-ack.
// Optional macro WB_ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests (default fixed m0 priority).
//
// state   | meaning
// IDLE    | no owner, arbitrate cyc requests
// GNT0    | m0 owns the shared slave bus
// GNT1    | m1 owns the shared slave bus
// ERR_ACK | one-cycle forced ack (data 0) to the owner after decode miss or timeout
module wb_bus_arbiter_2m4s
  import wb_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_DEC_MSB   = 31
) (
  input logic                  clk,
  input logic                  rst,
  wb_bus_arbiter_2m4s_if.slave bus
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  arb_state_e state_q, state_d;
  logic owner_q, owner_d;
  logic [15:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic pick;

  logic [WB_ADDR_W-1:0] m_addr;
  logic [WB_DATA_W-1:0] m_wdata, s_rdata, rdata;
  logic [WB_SEL_W-1:0]  m_sel;
  logic m_we, m_stb, m_cyc, ack;
  logic [N_SLV-1:0] dec_hot;
  logic dec_miss, slv_ack, stall, to_hit, in_gnt;

  assign m_addr  = owner_q ? bus.m1_addr_i : bus.m0_addr_i;
  assign m_wdata = owner_q ? bus.m1_data_i : bus.m0_data_i;
  assign m_sel   = owner_q ? bus.m1_sel_i  : bus.m0_sel_i;
  assign m_we    = owner_q ? bus.m1_we_i   : bus.m0_we_i;
  assign m_stb   = owner_q ? bus.m1_stb_i  : bus.m0_stb_i;
  assign m_cyc   = owner_q ? bus.m1_cyc_i  : bus.m0_cyc_i;

  wb_addr_decoder u_dec (
    .field_i (m_addr[ADDR_DEC_MSB -: 4]),
    .hot_o   (dec_hot),
    .miss_o  (dec_miss)
  );

  assign in_gnt  = (state_q == GNT0) || (state_q == GNT1);
  assign slv_ack = |(dec_hot & bus.s_ack_i);
  assign stall   = m_stb & ~dec_miss & ~slv_ack;
  // The stalled cycle that brings the count to TIMEOUT_CYCLES is the last one strobed.
  assign to_hit  = stall && (cnt_q == TO_LAST);

  always_comb begin
    s_rdata = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (dec_hot[k]) s_rdata = bus.s_data_i[k*WB_DATA_W +: WB_DATA_W];
    end
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign pick   = (bus.m0_cyc_i && bus.m1_cyc_i) ? ~last_q : ~bus.m0_cyc_i;
  assign last_d = ((state_q == IDLE) && (bus.m0_cyc_i || bus.m1_cyc_i)) ? pick : last_q;
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b0;
    else     last_q <= last_d;
  end
`else
  assign pick = ~bus.m0_cyc_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (bus.m0_cyc_i || bus.m1_cyc_i) begin
          owner_d = pick;
          state_d = pick ? GNT1 : GNT0;
        end
      end
      GNT0, GNT1: begin
        if (!m_cyc)                 state_d = IDLE;
        else if (m_stb && dec_miss) state_d = ERR_ACK;
        else if (to_hit)            state_d = ERR_ACK;
        else if (stall)             cnt_d   = cnt_q + 16'd1;
      end
      default: state_d = owner_q ? GNT1 : GNT0;
    endcase
    err_d = err_q | (state_d == ERR_ACK);
  end

  always_comb begin
    bus.s_addr_o  = '0;
    bus.s_data_o  = '0;
    bus.s_we_o    = 1'b0;
    bus.s_sel_o   = '0;
    bus.s_stb_o   = '0;
    bus.s_cyc_o   = '0;
    bus.m0_ack_o  = 1'b0;
    bus.m1_ack_o  = 1'b0;
    bus.m0_data_o = '0;
    bus.m1_data_o = '0;
    ack           = 1'b0;
    rdata         = '0;
    if (!rst) begin
      if (in_gnt) begin
        bus.s_addr_o = m_addr;
        bus.s_data_o = m_wdata;
        bus.s_we_o   = m_we;
        bus.s_sel_o  = m_sel;
        bus.s_stb_o  = dec_hot & {N_SLV{m_stb}};
        bus.s_cyc_o  = dec_hot & {N_SLV{m_cyc}};
        ack          = slv_ack & m_stb;
        rdata        = (ack && !m_we) ? s_rdata : '0;
      end else if (state_q == ERR_ACK) begin
        ack = 1'b1;
      end
      if (owner_q) begin
        bus.m1_ack_o  = ack;
        bus.m1_data_o = rdata;
      end else begin
        bus.m0_ack_o  = ack;
        bus.m0_data_o = rdata;
      end
    end
  end

  assign bus.bus_err_o = err_q;

endmodule
